sum_splitter: RTL and testbench

SUM_SPLITTER -- requirements
Module: sum_splitter

---
 rtl/sum_splitter.sv | 105 ++++++++++
 tb/tb_sum_splitter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_splitter.sv
// rtl/sum_splitter.sv - enumerates every operand triple summing to a latched target
module sum_splitter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op5,
    output logic [WIDTH-1:0] op3,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] t;
    logic             run;
    logic             xfer;
    logic             at_end;

    assign run    = (state == RUN);
    assign xfer   = run && out_ready;
    assign at_end = (a == MAX) && (b == MAX);

    // Outputs decode straight from the registered counters so they hold during stalls
    always_comb begin
        out_valid = run;
        op1       = '0;
        op5       = '0;
        op3       = '0;
        last      = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        if (run) begin
            op1  = a;
            op5  = b;
            op3  = t - a - b;
            last = at_end;
        end
    end

    // Next-state decode; abort beats the final transfer so no done pulse follows it
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (xfer && at_end) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register, target latch and (a, b) counter advanced only by a transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            t     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                t <= target;
                a <= '0;
                b <= '0;
            end else if (xfer) begin
                b <= b + 1'b1;
                if (b == MAX) begin
                    a <= a + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_splitter.sv
// tb/tb_sum_splitter.sv - scoreboard bench for sum_splitter
module tb_sum_splitter;

    localparam int W = 4;
    localparam int N = 1 << (2 * W);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] target;
    logic         abort;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] op1;
    logic [W-1:0] op5;
    logic [W-1:0] op3;
    logic         last;
    logic         busy;
    logic         done;

    sum_splitter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .target    (target),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .op1       (op1),
        .op5       (op5),
        .op3       (op3),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int             checks   = 0;
    int             failures = 0;
    int             xfers    = 0;
    int             dones    = 0;
    logic           rand_ready = 1'b0;
    logic [3*W:0]   exp_q[$];
    logic           stall_prev = 1'b0;
    logic [3*W:0]   held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: all (x, y) pairs in order, third operand chosen so the sum is T mod 2^W
    task automatic push_run(input logic [W-1:0] t);
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                logic [W-1:0] xa;
                logic [W-1:0] yb;
                logic [W-1:0] z;
                xa = W'(x);
                yb = W'(y);
                z  = W'(int'(t) - x - y);
                exp_q.push_back({xa, yb, z, (x == (1 << W) - 1) && (y == (1 << W) - 1)});
            end
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && stall_prev) begin
                check("stall_hold", {19'd0, op1, op5, op3, last}, {19'd0, held});
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer actual=%0h_%0h_%0h expected=none", op1, op5, op3);
                end else begin
                    check("triple", {19'd0, op1, op5, op3, last}, {19'd0, exp_q.pop_front()});
                end
            end
            if (done) begin
                dones++;
                check("done_shape", {30'd0, out_valid, busy}, 32'd1);
            end
            stall_prev = out_valid && !out_ready;
            held       = {op1, op5, op3, last};
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_start(input logic [W-1:0] t);
        @(posedge clk);
        #1;
        start  = 1'b1;
        target = t;
        @(posedge clk);
        #1;
        start  = 1'b0;
        target = W'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done_seen"}, 32'(i < budget), 32'd1);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
    endtask

    task automatic check_idle_zero(input string name);
        check(name, {18'd0, out_valid, last, busy, done, op1, op5, op3}, 32'd0);
    endtask

    initial begin
        int x0;
        int d0;
        logic [W-1:0] tr;
        rst_n     = 1'b0;
        start     = 1'b0;
        target    = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset_outputs");
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("idle_no_start");

        // Full run, target 5, always ready
        out_ready = 1'b1;
        push_run(W'(5));
        x0 = xfers;
        do_start(W'(5));
        @(negedge clk);
        check("start_latency", {31'd0, out_valid}, 32'd1);
        check("first_triple", {20'd0, op1, op5, op3}, {20'd0, 4'd0, 4'd0, 4'd5});
        wait_done("t5", 400);
        check("t5_count", 32'(xfers - x0), 32'(N));
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full run, target 0, random backpressure
        push_run(W'(0));
        x0 = xfers;
        do_start(W'(0));
        rand_ready = 1'b1;
        wait_done("t0", 3000);
        rand_ready = 1'b0;
        check("t0_count", 32'(xfers - x0), 32'(N));
        check("t0_queue_empty", 32'(exp_q.size()), 32'd0);

        // Start mid-run with a new target must be ignored
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_run(W'(3));
        do_start(W'(3));
        repeat (20) @(posedge clk);
        #1;
        start  = 1'b1;
        target = W'(4'hA);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy_hold", {31'd0, busy}, 32'd1);
        end
        #1 start = 1'b0;
        wait_done("t3", 400);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Abort coinciding with transfer #10
        tr = W'($urandom);
        push_run(tr);
        x0 = xfers;
        d0 = dones;
        do_start(tr);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && op5 == W'(9)) break;
        end
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_count", 32'(xfers - x0), 32'd10);
        check("abort_idle", {30'd0, out_valid, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(dones - d0), 32'd0);
        tr = W'($urandom);
        push_run(tr);
        x0 = xfers;
        do_start(tr);
        @(negedge clk);
        check("restart_triple", {20'd0, op1, op5, op3}, {20'd0, 4'd0, 4'd0, tr});
        rand_ready = 1'b1;
        wait_done("restart", 3000);
        rand_ready = 1'b0;
        check("restart_count", 32'(xfers - x0), 32'(N));

        // Reset pulse at transfer #100
        @(posedge clk);
        #1 out_ready = 1'b1;
        tr = W'($urandom);
        push_run(tr);
        d0 = dones;
        do_start(tr);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid && op1 == W'(6) && op5 == W'(3)) break;
        end
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle_zero("midrun_reset");
        repeat (4) @(negedge clk);
        check_idle_zero("post_reset_idle");
        check("reset_no_done", 32'(dones - d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
